// File: rtl/uart_pkg.sv
// Shared definitions for the multi-byte UART transmitter.
//   tx_state_t     : frame sequencer states
//   PAR_*          : encoding of the cfg_parity input
//   parity_enabled : true when a parity bit follows the data bits
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Mode 3 is reserved and behaves like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output.
//   clk, reset      : clock, asynchronous active-high reset (pointers/level only)
//   push, wr_data   : write request and data (ignored when full)
//   pop, rd_data    : read request (ignored when empty); rd_data shows the head entry
//   full, empty     : status flags
//   level           : number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_reg == FULL_LVL);
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  // A full FIFO refuses writes even if the same edge pops an entry.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The consumer pops and uses the head on the same edge, so the head
  // is presented combinationally from the storage array.
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_multi.sv
// UART transmitter with a TX FIFO and per-frame configuration.
//   clk, reset          : clock, asynchronous active-high reset
//   wr_data/valid/ready : byte write interface into the FIFO
//   cfg_div             : clocks per bit (values below 2 act as 2)
//   cfg_bits            : data bits minus 5
//   cfg_parity          : PAR_NONE / PAR_EVEN / PAR_ODD (3 = none)
//   cfg_stop2           : two stop bits when set
//   uart_txd            : registered serial output, idle high
//   busy                : frame in progress or FIFO not empty
//   fifo_level          : FIFO occupancy
module uart_tx_multi
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  tx_state_t        state_reg,  state_next;
  logic [DIV_W-1:0] cnt_reg,    cnt_next;
  logic [DIV_W-1:0] div_reg,    div_next;
  logic [1:0]       bits_reg,   bits_next;
  logic [1:0]       parity_reg, parity_next;
  logic             stop2_reg,  stop2_next;
  logic [7:0]       shift_reg,  shift_next;
  logic [2:0]       idx_reg,    idx_next;
  logic             par_reg,    par_next;
  logic             txd_reg,    txd_next;

  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rd_data;
  logic       load_frame;
  logic       cnt_done;
  logic [2:0] last_idx;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_valid),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign wr_ready = !fifo_full;
  assign busy     = (state_reg != IDLE) || !fifo_empty;
  assign uart_txd = txd_reg;
  assign cnt_done = (cnt_reg == '0);
  assign last_idx = 3'd4 + {1'b0, bits_reg};

  // Reload value for the bit-period down-counter: max(div, 2) - 1.
  function automatic logic [DIV_W-1:0] period_m1(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(1) : d - DIV_W'(1);
  endfunction

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    div_next    = div_reg;
    bits_next   = bits_reg;
    parity_next = parity_reg;
    stop2_next  = stop2_reg;
    shift_next  = shift_reg;
    idx_next    = idx_reg;
    par_next    = par_reg;
    fifo_pop    = 1'b0;
    load_frame  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) load_frame = 1'b1;
      end
      START: begin
        if (cnt_done) begin
          state_next = DATA;
          cnt_next   = period_m1(div_reg);
          idx_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DATA: begin
        if (cnt_done) begin
          cnt_next   = period_m1(div_reg);
          par_next   = par_reg ^ shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
          if (idx_reg == last_idx) begin
            idx_next   = '0;
            state_next = parity_enabled(parity_reg) ? PARITY : STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      PARITY: begin
        if (cnt_done) begin
          state_next = STOP;
          cnt_next   = period_m1(div_reg);
          idx_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      STOP: begin
        if (cnt_done) begin
          // idx counts completed stop bits while in STOP.
          if (stop2_reg && (idx_reg == '0)) begin
            idx_next = 3'd1;
            cnt_next = period_m1(div_reg);
          end else if (!fifo_empty) begin
            load_frame = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Frame start: pop the head byte and freeze the configuration for
    // the whole frame.
    if (load_frame) begin
      fifo_pop    = 1'b1;
      state_next  = START;
      cnt_next    = period_m1(cfg_div);
      div_next    = cfg_div;
      bits_next   = cfg_bits;
      parity_next = cfg_parity;
      stop2_next  = cfg_stop2;
      shift_next  = fifo_rd_data;
      idx_next    = '0;
      par_next    = 1'b0;
    end
  end

  // The line level is derived from the current state and registered, so
  // uart_txd trails the state by one clock and never glitches.
  always_comb begin
    txd_next = 1'b1;
    case (state_reg)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_reg[0];
      PARITY:  txd_next = (parity_reg == PAR_ODD) ? ~par_reg : par_reg;
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      div_reg    <= '0;
      bits_reg   <= '0;
      parity_reg <= PAR_NONE;
      stop2_reg  <= 1'b0;
      shift_reg  <= '0;
      idx_reg    <= '0;
      par_reg    <= 1'b0;
      txd_reg    <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      div_reg    <= div_next;
      bits_reg   <= bits_next;
      parity_reg <= parity_next;
      stop2_reg  <= stop2_next;
      shift_reg  <= shift_next;
      idx_reg    <= idx_next;
      par_reg    <= par_next;
      txd_reg    <= txd_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_multi.sv
// Self-checking bench for uart_tx_multi: every frame on uart_txd is compared
// bit by bit against a waveform built from the framing rules.
module tb_uart_tx_multi;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] cfg_div = 16'd4;
  logic [1:0]  cfg_bits = 2'd3;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_stop2 = 1'b0;
  logic        uart_txd;
  logic        busy;
  logic [3:0]  fifo_level;

  int compared = 0;
  int mismatched = 0;

  typedef bit bitq_t[$];

  uart_tx_multi #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .cfg_div    (cfg_div),
    .cfg_bits   (cfg_bits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .uart_txd   (uart_txd),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Reference: one entry per bit of the frame, start bit first.
  function automatic bitq_t model_frame(input logic [7:0] d, input int nbits,
                                        input int par, input bit stop2);
    bitq_t q;
    bit p;
    p = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (par == 1) q.push_back(p);
    else if (par == 2) q.push_back(!p);
    q.push_back(1'b1);
    if (stop2) q.push_back(1'b1);
    return q;
  endfunction

  // Called at a negedge not yet examined. Finds the start bit, checks its
  // latency, then every bit for its full period. Returns at the first
  // negedge after the frame.
  task automatic check_frame(input string name, input logic [7:0] d, input int nbits,
                             input int par, input bit stop2, input int div,
                             input int exp_lat, input bit last);
    bitq_t q;
    int per, lat, errs;
    bit bad;
    logic obs;
    q = model_frame(d, nbits, par, stop2);
    per = (div < 2) ? 2 : div;
    lat = 0;
    errs = 0;
    while (uart_txd !== 1'b0 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    compared++;
    if (uart_txd !== 1'b0) begin
      mismatched++;
      $display("FAIL %s start: txd=%b after %0d clocks, required 0", name, uart_txd, lat);
      return;
    end
    if (exp_lat >= 0) begin
      compared++;
      if (lat != exp_lat) begin
        mismatched++; errs++;
        $display("FAIL %s latency: observed %0d clocks, required %0d", name, lat, exp_lat);
      end
    end
    for (int i = 0; i < q.size(); i++) begin
      bad = 1'b0;
      obs = q[i];
      for (int j = 0; j < per; j++) begin
        if (!(i == 0 && j == 0)) @(negedge clk);
        if (uart_txd !== q[i]) begin
          bad = 1'b1;
          obs = uart_txd;
        end
      end
      compared++;
      if (bad) begin
        mismatched++; errs++;
        $display("FAIL %s bit%0d: observed %b, required %b", name, i, obs, q[i]);
      end
    end
    @(negedge clk);
    if (last) begin
      compared++;
      if (uart_txd !== 1'b1 || busy !== 1'b0) begin
        mismatched++; errs++;
        $display("FAIL %s end: txd=%b busy=%b, required txd=1 busy=0", name, uart_txd, busy);
      end
    end
    $display("[tb] frame %s byte=%h bits=%0d par=%0d stop2=%0d div=%0d errors=%0d",
             name, d, nbits, par, stop2, div, errs);
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    wr_valid = 1'b1;
    wr_data  = 8'h3C;
    repeat (3) @(negedge clk);
    compared++;
    if (uart_txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 4'd0 || wr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_hold: txd=%b busy=%b level=%0d ready=%b, required 1 0 0 1",
               uart_txd, busy, fifo_level, wr_ready);
    end
    wr_valid = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (uart_txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 4'd0 || wr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_idle: txd=%b busy=%b level=%0d ready=%b, required 1 0 0 1",
               uart_txd, busy, fifo_level, wr_ready);
    end
    $display("[tb] reset checked");
  endtask

  task automatic test_8n1;
    cfg_div = 16'd4; cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    write_byte(8'hA5);
    check_frame("8N1_A5", 8'hA5, 8, 0, 1'b0, 4, 2, 1'b1);
  endtask

  task automatic test_parity;
    cfg_div = 16'd4; cfg_bits = 2'd3; cfg_parity = 2'd1; cfg_stop2 = 1'b0;
    write_byte(8'hA5);
    check_frame("8E1_A5", 8'hA5, 8, 1, 1'b0, 4, 2, 1'b1);
    cfg_parity = 2'd2;
    write_byte(8'hA5);
    check_frame("8O1_A5", 8'hA5, 8, 2, 1'b0, 4, 2, 1'b1);
  endtask

  task automatic test_7bit_stop2;
    cfg_div = 16'd4; cfg_bits = 2'd2; cfg_parity = 2'd0; cfg_stop2 = 1'b1;
    write_byte(8'hA5);
    check_frame("7N2_A5", 8'hA5, 7, 0, 1'b1, 4, 2, 1'b1);
  endtask

  task automatic test_random;
    logic [7:0] d;
    for (int k = 0; k < 6; k++) begin
      d          = 8'($urandom);
      cfg_div    = 16'($urandom_range(0, 6));
      cfg_bits   = 2'($urandom_range(0, 3));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2  = 1'($urandom_range(0, 1));
      write_byte(d);
      check_frame($sformatf("rand%0d", k), d, int'(cfg_bits) + 5, int'(cfg_parity),
                  cfg_stop2, int'(cfg_div), 2, 1'b1);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [9];
    int d;
    d = $urandom_range(0, 4);
    cfg_div = 16'(d); cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    for (int k = 0; k < 9; k++) b[k] = 8'($urandom);
    fork
      begin
        int exp_lvl;
        @(negedge clk);
        wr_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
          wr_data = b[k];
          @(negedge clk);
          // k+1 bytes pushed; the first one is popped on the following edge.
          exp_lvl = (k + 1) - ((k >= 1) ? 1 : 0);
          compared++;
          if (fifo_level !== 4'(exp_lvl) || wr_ready !== (exp_lvl < DEPTH)) begin
            mismatched++;
            $display("FAIL b2b_level%0d: level=%0d ready=%b, required %0d %b",
                     k, fifo_level, wr_ready, exp_lvl, (exp_lvl < DEPTH));
          end
        end
        // Tenth byte offered while full must be refused.
        wr_data = 8'hEE;
        repeat (2) @(negedge clk);
        compared++;
        if (fifo_level !== 4'd8 || wr_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL b2b_full: level=%0d ready=%b, required 8 0", fifo_level, wr_ready);
        end
        wr_valid = 1'b0;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 9; k++)
          check_frame($sformatf("b2b%0d", k), b[k], 8, 0, 1'b0, d,
                      (k == 0) ? 2 : 0, (k == 8));
      end
    join
  endtask

  task automatic test_cfg_change;
    logic [7:0] b0, b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    cfg_div = 16'd4; cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    fork
      begin
        @(negedge clk);
        wr_valid = 1'b1; wr_data = b0;
        @(negedge clk);
        wr_data = b1;
        @(negedge clk);
        wr_valid = 1'b0;
        // Second push coincided with the first pop.
        compared++;
        if (fifo_level !== 4'd1) begin
          mismatched++;
          $display("FAIL cfg_pushpop_level: level=%0d, required 1", fifo_level);
        end
      end
      begin
        repeat (12) @(negedge clk);
        cfg_div = 16'd8;
      end
      begin
        @(negedge clk);
        @(negedge clk);
        check_frame("div4_first", b0, 8, 0, 1'b0, 4, 2, 1'b0);
        check_frame("div8_next", b1, 8, 0, 1'b0, 8, 0, 1'b1);
      end
    join
    cfg_div = 16'd4;
  endtask

  task automatic test_reset_mid_frame;
    bit stuck;
    cfg_div = 16'd4; cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
    write_byte(8'h00);
    write_byte(8'h5A);
    repeat (7) @(negedge clk);
    compared++;
    if (uart_txd !== 1'b0 || busy !== 1'b1 || fifo_level !== 4'd1) begin
      mismatched++;
      $display("FAIL rst_pre: txd=%b busy=%b level=%0d, required 0 1 1", uart_txd, busy, fifo_level);
    end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (uart_txd !== 1'b1 || busy !== 1'b0 || fifo_level !== 4'd0 || wr_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_async: txd=%b busy=%b level=%0d ready=%b, required 1 0 0 1",
               uart_txd, busy, fifo_level, wr_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    stuck = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || busy !== 1'b0) stuck = 1'b1;
    end
    compared++;
    if (stuck) begin
      mismatched++;
      $display("FAIL rst_discard: line left idle-high/not-busy after reset, required txd=1 busy=0");
    end
    $display("[tb] mid-frame reset checked");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_7bit_stop2();
    test_random();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
